// File: rtl/wb_cmp_pkg.sv
// Shared types and header/address geometry helpers for the compressed-wishbone master.
package wb_cmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADR,
    ST_WDATA,
    ST_TURN,
    ST_RDATA,
    ST_GAP
  } cmp_state_t;

  function automatic int unsigned adr_beats(input int unsigned aw, input int unsigned rw);
    return (aw + rw - 1) / rw;
  endfunction

  function automatic int unsigned burst_width(input int unsigned bmax);
    return (bmax > 2) ? $clog2(bmax) : 1;
  endfunction

  function automatic int unsigned hdr_we_pos(input int unsigned rw);
    return rw - 1;
  endfunction

  function automatic int unsigned hdr_burst_msb(input int unsigned rw);
    return rw - 2;
  endfunction

  function automatic int unsigned hdr_sel_width(input int unsigned rw);
    return rw / 8;
  endfunction

endpackage

// File: rtl/wb_cmp_timeout.sv
// Per-beat watchdog: reloads while cleared, counts down while enabled, pulses expire at zero.
module wb_cmp_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (clear) begin
      cnt <= LOAD;
    end else if (en && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/wb_compressor_p.sv
// Wishbone request to compressed cw_* bus master: header, multi-beat address, data beats with gap.
module wb_compressor_p
  import wb_cmp_pkg::*;
#(
  parameter int unsigned RW        = 16,
  parameter int unsigned AW        = 24,
  parameter int unsigned BURST_MAX = 8,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned BLW      = burst_width(BURST_MAX)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            wb_cyc,
  input  logic            wb_stb,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_adr,
  input  logic [RW-1:0]   wb_o_dat,
  input  logic [RW/8-1:0] wb_sel,
  input  logic [BLW-1:0]  wb_burst,
  output logic [RW-1:0]   wb_i_dat,
  output logic            wb_ack,
  output logic            wb_err,
  output logic [RW-1:0]   cw_io_o,
  input  logic [RW-1:0]   cw_io_i,
  output logic            cw_req,
  output logic            cw_dir,
  input  logic            cw_ack,
  input  logic            cw_err,
  output logic            busy
);

  localparam int unsigned AB      = adr_beats(AW, RW);
  localparam int unsigned AIW     = (AB > 1) ? $clog2(AB) : 1;
  localparam int unsigned BCW     = BLW + 1;
  localparam int unsigned HDR_WE  = hdr_we_pos(RW);
  localparam int unsigned HDR_BM  = hdr_burst_msb(RW);
  localparam int unsigned SW      = hdr_sel_width(RW);

  cmp_state_t state, state_nx;

  logic            we_q;
  logic [SW-1:0]   sel_q;
  logic [BLW-1:0]  burst_q;
  logic [AB*RW-1:0] adr_sr;
  logic [AIW-1:0]  adr_idx;
  logic [BCW-1:0]  beats;
  logic [RW-1:0]   hdr;
  logic            in_data, abort, beat_ok, beat_fail, expire, tmo_clear;
  logic            last_beat, adr_last;

  assign in_data   = (state == ST_WDATA) || (state == ST_RDATA);
  assign abort     = (state != ST_IDLE) && !wb_cyc;
  // Errors (slave or watchdog) win over a same-cycle ack; an abort suppresses both.
  assign beat_fail = in_data && !abort && (cw_err || expire);
  assign beat_ok   = in_data && !abort && !beat_fail && cw_ack;
  assign last_beat = (beats == (BCW'(burst_q) + BCW'(1)));
  assign adr_last  = (adr_idx == AIW'(AB - 1));
  assign tmo_clear = !in_data;

  always_comb begin
    hdr = '0;
    hdr[HDR_WE] = we_q;
    hdr[HDR_BM -: BLW] = burst_q;
    hdr[SW-1:0] = sel_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cw_req   = (state != ST_IDLE);
    busy     = (state != ST_IDLE);
    cw_dir   = 1'b0;
    cw_io_o  = '0;
    case (state)
      ST_IDLE:  if (wb_cyc && wb_stb) state_nx = ST_HDR;
      ST_HDR: begin
        cw_io_o  = hdr;
        state_nx = ST_ADR;
      end
      ST_ADR: begin
        cw_io_o = adr_sr[AB*RW-1 -: RW];
        if (adr_last) state_nx = we_q ? ST_WDATA : ST_TURN;
      end
      ST_WDATA: begin
        cw_io_o = wb_o_dat;
        if (beat_fail)    state_nx = ST_IDLE;
        else if (beat_ok) state_nx = ST_GAP;
      end
      ST_TURN: begin
        cw_dir   = 1'b1;
        state_nx = ST_RDATA;
      end
      ST_RDATA: begin
        cw_dir = 1'b1;
        if (beat_fail)    state_nx = ST_IDLE;
        else if (beat_ok) state_nx = ST_GAP;
      end
      ST_GAP: begin
        cw_dir   = !we_q;
        state_nx = last_beat ? ST_IDLE : (we_q ? ST_WDATA : ST_RDATA);
      end
      default: state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      we_q     <= 1'b0;
      sel_q    <= '0;
      burst_q  <= '0;
      adr_sr   <= '0;
      adr_idx  <= '0;
      beats    <= '0;
      wb_ack   <= 1'b0;
      wb_err   <= 1'b0;
      wb_i_dat <= '0;
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      if (state == ST_IDLE) begin
        beats   <= '0;
        adr_idx <= '0;
        if (wb_cyc && wb_stb) begin
          we_q    <= wb_we;
          sel_q   <= wb_sel;
          burst_q <= wb_burst;
          adr_sr  <= (AB*RW)'(wb_adr);
        end
      end
      if (state == ST_ADR) begin
        adr_sr  <= adr_sr << RW;
        adr_idx <= adr_idx + AIW'(1);
      end
      if (beat_ok) begin
        wb_ack <= 1'b1;
        beats  <= beats + BCW'(1);
        if (state == ST_RDATA) wb_i_dat <= cw_io_i;
      end
      if (beat_fail) wb_err <= 1'b1;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_tmo
      wb_cmp_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk    (i_clk),
        .rst_n  (i_rst),
        .clear  (tmo_clear),
        .en     (in_data),
        .expire (expire)
      );
    end else begin : g_no_tmo
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_compressor_p.sv
// Directed/randomized bench for wb_compressor_p checked against a transaction-level bus model.
module tb_wb_compressor_p;

  logic        i_clk, i_rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [23:0] wb_adr;
  logic [15:0] wb_o_dat;
  logic [1:0]  wb_sel;
  logic [2:0]  wb_burst;
  logic [15:0] wb_i_dat;
  logic        wb_ack, wb_err;
  logic [15:0] cw_io_o, cw_io_i;
  logic        cw_req, cw_dir, cw_ack, cw_err, busy;

  int checks = 0;
  int failures = 0;

  wb_compressor_p #(.RW(16), .AW(24), .BURST_MAX(8), .TIMEOUT(10)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_o_dat(wb_o_dat), .wb_sel(wb_sel), .wb_burst(wb_burst),
    .wb_i_dat(wb_i_dat), .wb_ack(wb_ack), .wb_err(wb_err),
    .cw_io_o(cw_io_o), .cw_io_i(cw_io_i), .cw_req(cw_req), .cw_dir(cw_dir),
    .cw_ack(cw_ack), .cw_err(cw_err), .busy(busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Drives one wishbone request and plays a slave with random waits; expected bus words
  // come from the transaction fields (header layout, MS-first address chunks, data beats).
  task automatic run_txn(input bit we, input logic [23:0] adr, input int burst,
                         input logic [1:0] sel, input int max_wait, input int err_beat);
    logic [15:0] wdat;
    int w;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_burst = 3'(burst);
    #1 chk("idle_req", cw_req, 0);
    tick(); wb_stb = 0;
    #1 chk("hdr_io", cw_io_o, (32'(we) << 15) | (32'(burst) << 12) | 32'(sel));
    chk("hdr_req", cw_req, 1);
    tick(); #1 chk("adr_hi", cw_io_o, 32'(adr) >> 16);
    tick(); #1 chk("adr_lo", cw_io_o, 32'(adr) & 32'hFFFF);
    tick();
    if (!we) begin
      #1 chk("turn_dir", cw_dir, 1);
      chk("turn_io", cw_io_o, 0);
      tick();
    end
    for (int b = 0; b <= burst; b++) begin
      w = $urandom_range(0, max_wait);
      for (int i = 0; i < w; i++) begin
        wdat = 16'($urandom); wb_o_dat = wdat; cw_io_i = 16'($urandom);
        #1 chk("wait_io", cw_io_o, we ? 32'(wdat) : 0);
        chk("wait_dir", cw_dir, we ? 0 : 1);
        chk("wait_noack", wb_ack, 0);
        tick();
      end
      wdat = 16'($urandom); wb_o_dat = wdat; cw_io_i = 16'h0100 + 16'(b);
      if (b == err_beat) cw_err = 1; else cw_ack = 1;
      #1 chk("beat_io", cw_io_o, we ? 32'(wdat) : 0);
      tick(); cw_ack = 0; cw_err = 0; cw_io_i = 16'($urandom);
      #1;
      if (b == err_beat) begin
        chk("err_resp", wb_err, 1);
        chk("err_noack", wb_ack, 0);
        chk("err_req", cw_req, 0);
        for (int i = 0; i < 3; i++) begin
          tick(); #1 chk("post_err_ack", wb_ack, 0);
          chk("post_err_err", wb_err, 0);
        end
        wb_cyc = 0;
        return;
      end
      chk("beat_ack", wb_ack, 1);
      chk("beat_noerr", wb_err, 0);
      if (!we) chk("rd_data", wb_i_dat, 32'h0100 + 32'(b));
      chk("gap_dir", cw_dir, we ? 0 : 1);
      chk("gap_req", cw_req, 1);
      tick();
    end
    #1 chk("end_req", cw_req, 0);
    chk("end_busy", busy, 0);
    chk("end_ack", wb_ack, 0);
    wb_cyc = 0;
  endtask

  int got;

  initial begin
    i_rst = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_o_dat = '0;
    wb_sel = '0; wb_burst = '0; cw_io_i = '0; cw_ack = 0; cw_err = 0;
    #12;
    chk("rst_req", cw_req, 0);
    chk("rst_dir", cw_dir, 0);
    chk("rst_io", cw_io_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", wb_ack, 0);
    chk("rst_idat", wb_i_dat, 0);
    i_rst = 1;
    tick();

    // single write 0x00ABCD <- 0x1234, immediate ack
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 24'h00ABCD; wb_sel = 2'b11; wb_burst = 0;
    tick(); wb_stb = 0;
    #1 chk("w1_hdr", cw_io_o, 16'h8003);
    tick(); #1 chk("w1_adr0", cw_io_o, 16'h0000);
    tick(); #1 chk("w1_adr1", cw_io_o, 16'hABCD);
    tick(); wb_o_dat = 16'h1234; cw_ack = 1;
    #1 chk("w1_data", cw_io_o, 16'h1234);
    chk("w1_noack_yet", wb_ack, 0);
    tick(); cw_ack = 0;
    #1 chk("w1_ack", wb_ack, 1);
    chk("w1_gap_req", cw_req, 1);
    tick(); #1 chk("w1_idle_req", cw_req, 0);
    chk("w1_ack_pulse", wb_ack, 0);
    wb_cyc = 0;
    tick();

    // read burst of 8 with random waits
    run_txn(0, 24'($urandom), 7, 2'($urandom), 3, -1);
    tick();
    // write keeps last read data
    run_txn(1, 24'($urandom), 1, 2'b01, 2, -1);
    chk("idat_hold", wb_i_dat, 16'h0107);
    tick();

    // error on beat 3 of a 4-beat write
    run_txn(1, 24'($urandom), 3, 2'b11, 2, 2);
    tick();

    // timeout on a read that is never acked
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 24'($urandom); wb_sel = 2'b10; wb_burst = 0;
    tick(); wb_stb = 0;
    tick(); tick(); tick(); tick();
    #1 chk("tmo_in_rdata", cw_dir, 1);
    got = -1;
    for (int k = 1; k <= 20 && got < 0; k++) begin
      tick();
      if (wb_err === 1'b1) got = k;
    end
    chk("tmo_cycles", 32'(got), 11);
    #1 chk("tmo_req", cw_req, 0);
    wb_cyc = 0;
    tick();

    // cycle dropped during address phase
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 24'h123456; wb_sel = 2'b11; wb_burst = 3;
    tick(); wb_stb = 0;
    tick(); wb_cyc = 0;
    #1 chk("abort_adr_req", cw_req, 1);
    tick();
    #1 chk("abort_req", cw_req, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_noack", wb_ack, 0);
      chk("abort_noerr", wb_err, 0);
      tick();
    end
    run_txn(1, 24'($urandom), 1, 2'b11, 3, -1);
    tick();

    // asynchronous reset during write data
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 24'hFEDCBA; wb_sel = 2'b11; wb_burst = 2;
    tick(); wb_stb = 0;
    tick(); tick(); tick();
    wb_o_dat = 16'h5A5A;
    #1 chk("ar_wdata", cw_io_o, 16'h5A5A);
    #2 i_rst = 0;
    #1 chk("ar_req", cw_req, 0);
    chk("ar_io", cw_io_o, 0);
    chk("ar_dir", cw_dir, 0);
    chk("ar_busy", busy, 0);
    chk("ar_idat", wb_i_dat, 0);
    chk("ar_ack", wb_ack, 0);
    chk("ar_err", wb_err, 0);
    #1 wb_cyc = 0; i_rst = 1;
    tick();
    run_txn(0, 24'($urandom), 1, 2'b01, 3, -1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
